// File: rtl/trap_unit_if.sv
// CSR access bus between the CSR decoder (master) and the trap unit (slave).
interface trap_unit_if;
    logic        rd_en;
    logic        wr_en;
    logic [11:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output rd_en,
        output wr_en,
        output addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/trap_unit.sv
// M-mode trap CSRs (mtvec, mip, mie, mepc, mcause, mtval), trap prioritisation,
// trap target generation and mret return address.
module trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    trap_unit_if.slave  bus,
    input  logic        i_global_mie,
    input  logic        i_inst_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_next_pc,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_fault_addr,
    input  logic        i_exc_inst_mis,
    input  logic        i_exc_illegal,
    input  logic        i_exc_ebreak,
    input  logic        i_exc_ecall,
    input  logic        i_exc_ld_mis,
    input  logic        i_exc_st_mis,
    input  logic        i_mtip,
    input  logic        i_msip,
    input  logic        i_meip_async,
    input  logic        i_mret,
    output logic        o_trap,
    output logic [31:0] o_trap_pc,
    output logic [31:0] o_mret_pc
);
    localparam logic [11:0] ADDR_MIE    = 12'h304;
    localparam logic [11:0] ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] ADDR_MEPC   = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] ADDR_MTVAL  = 12'h343;
    localparam logic [11:0] ADDR_MIP    = 12'h344;
    localparam logic [31:0] MIE_MASK    = 32'h0000_0888;

    logic [31:0] r_mtvec;
    logic [31:0] r_mie;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic        r_meip_sync1;
    logic        r_meip_sync2;

    logic [31:0] w_mip;
    logic [31:0] w_irq_pend;
    logic        w_int_req;
    logic [3:0]  w_int_cause;
    logic        w_exc_req;
    logic [3:0]  w_exc_code;
    logic [31:0] w_exc_tval;
    logic        w_trap;
    logic [31:0] w_base;
    logic        w_wr_mtvec;
    logic        w_wr_mie;
    logic        w_wr_mepc;
    logic        w_wr_mcause;
    logic        w_wr_mtval;

    // next_pc is reserved for a later revision; mret only matters to csr/fetch;
    // mepc keeps only a word-aligned PC.
    logic w_unused_sigs;
    assign w_unused_sigs = ^{i_next_pc, i_mret, i_pc[1:0]};

    assign w_mip      = {20'b0, r_meip_sync2, 3'b0, i_mtip, 3'b0, i_msip, 3'b0};
    assign w_irq_pend = w_mip & r_mie;
    assign w_int_req  = i_inst_valid & i_global_mie & (|w_irq_pend);
    assign w_exc_req  = i_inst_valid & (i_exc_inst_mis | i_exc_illegal | i_exc_ebreak |
                                        i_exc_ecall | i_exc_ld_mis | i_exc_st_mis);
    // Reset drops any trap that would otherwise be taken this cycle.
    assign w_trap     = ~rst & (w_int_req | w_exc_req);
    assign w_base     = {r_mtvec[31:2], 2'b00};

    assign w_wr_mtvec  = bus.wr_en && (bus.addr == ADDR_MTVEC);
    assign w_wr_mie    = bus.wr_en && (bus.addr == ADDR_MIE);
    assign w_wr_mepc   = bus.wr_en && (bus.addr == ADDR_MEPC);
    assign w_wr_mcause = bus.wr_en && (bus.addr == ADDR_MCAUSE);
    assign w_wr_mtval  = bus.wr_en && (bus.addr == ADDR_MTVAL);

    // Interrupt cause: external beats software beats timer.
    always_comb begin
        w_int_cause = 4'd7;
        if (w_irq_pend[11])
            w_int_cause = 4'd11;
        else if (w_irq_pend[3])
            w_int_cause = 4'd3;
    end

    // Exception code and trap value, highest priority first.
    always_comb begin
        w_exc_code = 4'd6;
        w_exc_tval = i_fault_addr;
        if (i_exc_inst_mis) begin
            w_exc_code = 4'd0;
            w_exc_tval = i_fault_addr;
        end else if (i_exc_illegal) begin
            w_exc_code = 4'd2;
            w_exc_tval = i_inst;
        end else if (i_exc_ebreak) begin
            w_exc_code = 4'd3;
            w_exc_tval = i_pc;
        end else if (i_exc_ecall) begin
            w_exc_code = 4'd11;
            w_exc_tval = 32'h0;
        end else if (i_exc_ld_mis) begin
            w_exc_code = 4'd4;
            w_exc_tval = i_fault_addr;
        end
    end

    // Redirect target: vectored only for interrupts in MODE=1.
    always_comb begin
        o_trap    = w_trap;
        o_trap_pc = 32'h0;
        if (w_trap) begin
            if (w_int_req && (r_mtvec[1:0] == 2'b01))
                o_trap_pc = w_base + {26'b0, w_int_cause, 2'b00};
            else
                o_trap_pc = w_base;
        end
    end

    assign o_mret_pc = {r_mepc, 2'b00};

    // CSR read mux; unmapped addresses and idle cycles read zero.
    always_comb begin
        bus.rd_data = 32'h0;
        if (bus.rd_en) begin
            case (bus.addr)
                ADDR_MTVEC:  bus.rd_data = r_mtvec;
                ADDR_MIP:    bus.rd_data = w_mip;
                ADDR_MIE:    bus.rd_data = r_mie;
                ADDR_MEPC:   bus.rd_data = {r_mepc, 2'b00};
                ADDR_MCAUSE: bus.rd_data = r_mcause;
                ADDR_MTVAL:  bus.rd_data = r_mtval;
                default:     bus.rd_data = 32'h0;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous external interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meip_sync1 <= 1'b0;
            r_meip_sync2 <= 1'b0;
        end else begin
            r_meip_sync1 <= i_meip_async;
            r_meip_sync2 <= r_meip_sync1;
        end
    end

    // mtvec/mie take software writes regardless of a trap; reserved MODE values are rejected.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtvec <= MTVEC_RESET;
            r_mie   <= 32'h0;
        end else begin
            if (w_wr_mtvec) begin
                r_mtvec[31:2] <= bus.wr_data[31:2];
                if (bus.wr_data[1:0] <= 2'b01)
                    r_mtvec[1:0] <= bus.wr_data[1:0];
            end
            if (w_wr_mie)
                r_mie <= bus.wr_data & MIE_MASK;
        end
    end

    // Trap state capture; a trap overrides a same-cycle software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mepc   <= 30'h0;
            r_mcause <= 32'h0;
            r_mtval  <= 32'h0;
        end else if (w_trap) begin
            r_mepc <= i_pc[31:2];
            if (w_int_req) begin
                r_mcause <= {1'b1, 27'b0, w_int_cause};
            end else begin
                r_mcause <= {28'b0, w_exc_code};
                r_mtval  <= w_exc_tval;
            end
        end else begin
            if (w_wr_mepc)
                r_mepc <= bus.wr_data[31:2];
            if (w_wr_mcause)
                r_mcause <= bus.wr_data;
            if (w_wr_mtval)
                r_mtval <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios then randomized traffic,
// compared every cycle against a behavioural model of the trap CSRs.
module tb_trap_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        global_mie, inst_valid;
    logic [31:0] pc, next_pc, inst, fault_addr;
    logic        exc_inst_mis, exc_illegal, exc_ebreak, exc_ecall, exc_ld_mis, exc_st_mis;
    logic        mtip, msip, meip_async, mret;
    logic        trap;
    logic [31:0] trap_pc, mret_pc;

    trap_unit_if bus ();

    trap_unit #(.MTVEC_RESET(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .i_global_mie   (global_mie),
        .i_inst_valid   (inst_valid),
        .i_pc           (pc),
        .i_next_pc      (next_pc),
        .i_inst         (inst),
        .i_fault_addr   (fault_addr),
        .i_exc_inst_mis (exc_inst_mis),
        .i_exc_illegal  (exc_illegal),
        .i_exc_ebreak   (exc_ebreak),
        .i_exc_ecall    (exc_ecall),
        .i_exc_ld_mis   (exc_ld_mis),
        .i_exc_st_mis   (exc_st_mis),
        .i_mtip         (mtip),
        .i_msip         (msip),
        .i_meip_async   (meip_async),
        .i_mret         (mret),
        .o_trap         (trap),
        .o_trap_pc      (trap_pc),
        .o_mret_pc      (mret_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (architectural values as software would read them).
    logic [31:0] m_mtvec, m_mie, m_mepc, m_mcause, m_mtval;
    logic        meip_hist[$];   // meip_async samples, newest first

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic meip_visible();
        return (meip_hist.size() >= 2) ? meip_hist[1] : 1'b0;
    endfunction

    function automatic logic [31:0] model_mip();
        logic [31:0] v;
        v = 32'h0;
        v[11] = meip_visible();
        v[7]  = mtip;
        v[3]  = msip;
        return v;
    endfunction

    // Interrupt decision: first enabled+pending cause in MEI, MSI, MTI order.
    function automatic int model_int_cause();
        int order[3] = '{11, 3, 7};
        logic [31:0] pend;
        pend = model_mip() & m_mie;
        if (!(inst_valid && global_mie)) return -1;
        foreach (order[k]) if (pend[order[k]]) return order[k];
        return -1;
    endfunction

    // Exception decision: first raised exception in architectural priority order.
    function automatic int model_exc_code();
        logic flags[6];
        int   codes[6] = '{0, 2, 3, 11, 4, 6};
        flags = '{exc_inst_mis, exc_illegal, exc_ebreak, exc_ecall, exc_ld_mis, exc_st_mis};
        if (!inst_valid) return -1;
        foreach (flags[k]) if (flags[k]) return codes[k];
        return -1;
    endfunction

    function automatic logic [31:0] model_tval(input int code);
        case (code)
            2:       return inst;
            3:       return pc;
            11:      return 32'h0;
            default: return fault_addr;
        endcase
    endfunction

    function automatic logic [31:0] model_read();
        if (!bus.rd_en) return 32'h0;
        case (bus.addr)
            12'h305: return m_mtvec;
            12'h344: return model_mip();
            12'h304: return m_mie;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    // Compare all combinational outputs with the model for the current inputs.
    task automatic settle();
        int ic, ec;
        logic e_trap;
        logic [31:0] e_pc;
        #1;
        ic = model_int_cause();
        ec = model_exc_code();
        e_trap = !rst && (ic >= 0 || ec >= 0);
        e_pc = 32'h0;
        if (e_trap) begin
            e_pc = m_mtvec & ~32'h3;
            if (ic >= 0 && m_mtvec[1:0] == 2'b01) e_pc = e_pc + 32'(4 * ic);
        end
        chk("trap", {31'b0, trap}, {31'b0, e_trap});
        chk("trap_pc", trap_pc, e_pc);
        chk("rd_data", bus.rd_data, model_read());
        chk("mret_pc", mret_pc, m_mepc);
    endtask

    // Apply one clock edge to the model and DUT, return at the next falling edge.
    task automatic advance();
        int ic, ec;
        logic took;
        @(posedge clk);
        ic = model_int_cause();
        ec = model_exc_code();
        if (rst) begin
            m_mtvec = 32'h0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            meip_hist.delete();
        end else begin
            took = (ic >= 0 || ec >= 0);
            if (bus.wr_en && bus.addr == 12'h305)
                m_mtvec = {bus.wr_data[31:2], (bus.wr_data[1:0] < 2) ? bus.wr_data[1:0] : m_mtvec[1:0]};
            if (bus.wr_en && bus.addr == 12'h304)
                m_mie = bus.wr_data & 32'h888;
            if (took) begin
                m_mepc = pc & ~32'h3;
                if (ic >= 0) m_mcause = 32'h8000_0000 | 32'(ic);
                else begin
                    m_mcause = 32'(ec);
                    m_mtval  = model_tval(ec);
                end
            end else if (bus.wr_en) begin
                if (bus.addr == 12'h341) m_mepc = bus.wr_data & ~32'h3;
                if (bus.addr == 12'h342) m_mcause = bus.wr_data;
                if (bus.addr == 12'h343) m_mtval = bus.wr_data;
            end
            meip_hist.push_front(meip_async);
            if (meip_hist.size() > 2) void'(meip_hist.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rd_en = 0; bus.wr_en = 0; bus.addr = 0; bus.wr_data = 0;
        inst_valid = 0; exc_inst_mis = 0; exc_illegal = 0; exc_ebreak = 0;
        exc_ecall = 0; exc_ld_mis = 0; exc_st_mis = 0; mret = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        idle_inputs();
        bus.wr_en = 1; bus.addr = a; bus.wr_data = d;
        settle();
        advance();
        bus.wr_en = 0;
    endtask

    task automatic csr_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
        idle_inputs();
        bus.rd_en = 1; bus.addr = a;
        settle();
        chk(tag, bus.rd_data, exp);
        advance();
        bus.rd_en = 0;
    endtask

    initial begin
        rst = 1; global_mie = 0; pc = 0; next_pc = 0; inst = 0; fault_addr = 0;
        mtip = 0; msip = 0; meip_async = 0;
        m_mtvec = 'x; m_mie = 'x; m_mepc = 'x; m_mcause = 'x; m_mtval = 'x;
        idle_inputs();
        @(negedge clk);
        #1;
        chk("trap_in_reset", {31'b0, trap}, 32'h0);
        advance();
        rst = 0;

        // Reset values
        csr_expect("rst_mie", 12'h304, 32'h0);
        csr_expect("rst_mepc", 12'h341, 32'h0);
        csr_expect("rst_mcause", 12'h342, 32'h0);
        csr_expect("rst_mtval", 12'h343, 32'h0);
        csr_expect("rst_mtvec", 12'h305, 32'h0);
        csr_expect("unmapped_rd", 12'h300, 32'h0);

        // mtvec MODE filtering
        csr_write(12'h305, 32'h0000_0203);
        csr_expect("mtvec_mode3", 12'h305, 32'h0000_0200);
        csr_write(12'h305, 32'h0000_0201);
        csr_expect("mtvec_mode1", 12'h305, 32'h0000_0201);

        // Vectored interrupt, MSI beats MTI
        csr_write(12'h304, 32'hFFFF_FFFF);
        csr_expect("mie_mask", 12'h304, 32'h0000_0888);
        idle_inputs();
        global_mie = 1; mtip = 1; msip = 1; pc = 32'h40; inst_valid = 1;
        settle();
        chk("int_trap", {31'b0, trap}, 32'h1);
        chk("int_trap_pc", trap_pc, 32'h0000_020C);
        advance();
        csr_expect("int_mcause", 12'h342, 32'h8000_0003);
        csr_expect("int_mepc", 12'h341, 32'h0000_0040);
        csr_expect("mip_read", 12'h344, 32'h0000_0088);

        // Exception priority: illegal beats load misaligned
        global_mie = 0; mtip = 0; msip = 0;
        idle_inputs();
        inst_valid = 1; exc_ld_mis = 1; exc_illegal = 1; fault_addr = 32'h1001;
        inst = 32'hFFFF_FFFF; pc = 32'h44;
        settle();
        chk("exc_trap_pc", trap_pc, 32'h0000_0200);
        advance();
        csr_expect("exc_mcause", 12'h342, 32'h2);
        csr_expect("exc_mtval", 12'h343, 32'hFFFF_FFFF);

        // External interrupt through the synchroniser
        csr_write(12'h304, 32'h0000_0800);
        idle_inputs();
        global_mie = 1; inst_valid = 1; meip_async = 1; pc = 32'h48;
        settle();
        chk("meip_edge0", {31'b0, trap}, 32'h0);
        advance();
        settle();
        chk("meip_edge1", {31'b0, trap}, 32'h0);
        advance();
        inst_valid = 0;
        settle();
        chk("meip_no_valid", {31'b0, trap}, 32'h0);
        inst_valid = 1;
        settle();
        chk("meip_edge2", {31'b0, trap}, 32'h1);
        chk("meip_trap_pc", trap_pc, 32'h0000_022C);
        advance();
        meip_async = 0; global_mie = 0;

        // Trap wins over a same-cycle mepc write; then mret
        idle_inputs();
        bus.wr_en = 1; bus.addr = 12'h341; bus.wr_data = 32'h103;
        exc_ecall = 1; inst_valid = 1; pc = 32'h80;
        settle();
        advance();
        idle_inputs();
        mret = 1; inst_valid = 1;
        settle();
        chk("mret_pc", mret_pc, 32'h0000_0080);
        advance();
        csr_expect("ecall_mepc", 12'h341, 32'h80);
        csr_expect("ecall_mcause", 12'h342, 32'd11);
        csr_write(12'h341, 32'h0000_0103);
        csr_expect("mepc_align", 12'h341, 32'h0000_0100);

        // Reset while a trap is requested
        idle_inputs();
        rst = 1; inst_valid = 1; exc_ebreak = 1;
        settle();
        chk("rst_drops_trap", {31'b0, trap}, 32'h0);
        advance();
        rst = 0;
        csr_expect("rst2_mcause", 12'h342, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [11:0] addrs[8] = '{12'h305, 12'h344, 12'h304, 12'h341,
                                      12'h342, 12'h343, 12'h300, 12'h7C0};
            rst          = ($urandom_range(0, 99) == 0);
            bus.rd_en    = $urandom_range(0, 1);
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.addr     = addrs[$urandom_range(0, 7)];
            bus.wr_data  = $urandom;
            global_mie   = $urandom_range(0, 1);
            inst_valid   = ($urandom_range(0, 3) != 0);
            pc           = $urandom;
            next_pc      = pc + 4;
            inst         = $urandom;
            fault_addr   = $urandom;
            exc_inst_mis = ($urandom_range(0, 15) == 0);
            exc_illegal  = ($urandom_range(0, 15) == 0);
            exc_ebreak   = ($urandom_range(0, 15) == 0);
            exc_ecall    = ($urandom_range(0, 15) == 0);
            exc_ld_mis   = ($urandom_range(0, 15) == 0);
            exc_st_mis   = ($urandom_range(0, 15) == 0);
            mret         = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) mtip = ~mtip;
            if ($urandom_range(0, 7) == 0) msip = ~msip;
            if ($urandom_range(0, 5) == 0) meip_async = ~meip_async;
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
